// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage (optional M) feeding a DEPTH-entry FIFO of decoded bundles.
// Latency 1 cycle into an empty FIFO; in_ready drops only when full (no same-cycle bypass).
module decode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Flush wins over any same-cycle push or pop.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = din;
        wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      ImmType,
  output logic            PCtoRegSrc,
  output logic [3:0]      ALUType,
  output logic [2:0]      BType,
  output logic [1:0]      PCSrc,
  output logic            MemWrite,
  output logic            MemRead,
  output logic            RDSrc,
  output logic            MemtoRegSrc,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic [2:0]      DataSize,
  output logic            is_mul,
  output logic [2:0]      mul_op,
  output logic            illegal
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      imm_type;
    logic            pc_to_reg_src;
    logic [3:0]      alu_type;
    logic [2:0]      b_type;
    logic [1:0]      pc_src;
    logic            mem_write;
    logic            mem_read;
    logic            rd_src;
    logic            mem_to_reg_src;
    logic            alu_src;
    logic            reg_write;
    logic [2:0]      data_size;
    logic            is_mul;
    logic [2:0]      mul_op;
    logic            illegal;
  } bundle_t;

  localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2,
                         IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;

  bundle_t            dec, head, vis;
  logic [4:0]         opc;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic               ill;
  logic signed [31:0] imm32;
  logic               fifo_full, fifo_empty;

  always_comb begin
    opc = in_instr[6:2];
    f3  = in_instr[14:12];
    f7  = in_instr[31:25];
    ill = 1'b0;
    dec = '0;
    dec.pc     = in_pc;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    dec.b_type = 3'b010;
    if (in_instr[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc)
        5'b01100: begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          if (f7 == 7'b0000000) begin
            dec.alu_type = {1'b0, f3};
          end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
            dec.alu_type = {1'b1, f3};
          end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
            dec.is_mul = 1'b1;
            dec.mul_op = f3;
          end else begin
            ill = 1'b1;
          end
        end
        5'b00100: begin
          dec.imm_type  = IMM_I;
          dec.reg_write = 1'b1;
          dec.alu_type  = {(f3 == 3'b101) && in_instr[30], f3};
          // RV64 shifts carry a 6-bit shamt, so only instr[31:26] is the funct field.
          if (XLEN == 64) begin
            if (f3 == 3'b001 && in_instr[31:26] != 6'b000000) ill = 1'b1;
            if (f3 == 3'b101 && in_instr[31:26] != 6'b000000 && in_instr[31:26] != 6'b010000) ill = 1'b1;
          end else begin
            if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
            if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
          end
        end
        5'b00000: begin
          dec.imm_type       = IMM_I;
          dec.mem_read       = 1'b1;
          dec.mem_to_reg_src = 1'b1;
          dec.reg_write      = 1'b1;
          dec.data_size      = f3;
          if (f3 == 3'b111 || ((f3 == 3'b011 || f3 == 3'b110) && XLEN != 64)) ill = 1'b1;
        end
        5'b01000: begin
          dec.imm_type  = IMM_S;
          dec.mem_write = 1'b1;
          dec.data_size = f3;
          if (f3[2] || (f3 == 3'b011 && XLEN != 64)) ill = 1'b1;
        end
        5'b11000: begin
          dec.imm_type = IMM_B;
          dec.b_type   = f3;
          dec.alu_type = {1'b0, f3};
          dec.pc_src   = 2'd3;
          if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
        end
        5'b11001: begin
          dec.imm_type  = IMM_I;
          dec.pc_src    = 2'd2;
          dec.rd_src    = 1'b1;
          dec.reg_write = 1'b1;
          dec.b_type    = 3'b000;
          if (f3 != 3'b000) ill = 1'b1;
        end
        5'b11011: begin
          dec.imm_type  = IMM_J;
          dec.pc_src    = 2'd1;
          dec.rd_src    = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_type  = 4'hf;
        end
        5'b00101: begin
          dec.imm_type      = IMM_U;
          dec.pc_to_reg_src = 1'b1;
          dec.rd_src        = 1'b1;
          dec.reg_write     = 1'b1;
          dec.alu_type      = 4'hf;
        end
        5'b01101: begin
          dec.imm_type  = IMM_U;
          dec.reg_write = 1'b1;
          dec.alu_type  = 4'hf;
        end
        default: ill = 1'b1;
      endcase
    end

    case (dec.imm_type)
      IMM_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U:   imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.imm = XLEN'(imm32);

    // Illegal bundles still flow down the pipe but must not cause side effects.
    if (ill) begin
      dec.illegal   = 1'b1;
      dec.reg_write = 1'b0;
      dec.mem_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.pc_src    = 2'd0;
    end
  end

  decode_fifo #(.WIDTH($bits(bundle_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .flush (flush),
    .push  (in_valid && in_ready),
    .pop   (out_valid && out_ready),
    .din   (dec),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign vis       = fifo_empty ? '0 : head;

  assign out_pc      = vis.pc;
  assign rs1         = vis.rs1;
  assign rs2         = vis.rs2;
  assign rd          = vis.rd;
  assign imm         = vis.imm;
  assign ImmType     = vis.imm_type;
  assign PCtoRegSrc  = vis.pc_to_reg_src;
  assign ALUType     = vis.alu_type;
  assign BType       = vis.b_type;
  assign PCSrc       = vis.pc_src;
  assign MemWrite    = vis.mem_write;
  assign MemRead     = vis.mem_read;
  assign RDSrc       = vis.rd_src;
  assign MemtoRegSrc = vis.mem_to_reg_src;
  assign ALUSrc      = vis.alu_src;
  assign RegWrite    = vis.reg_write;
  assign DataSize    = vis.data_size;
  assign is_mul      = vis.is_mul;
  assign mul_op      = vis.mul_op;
  assign illegal     = vis.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a queue-based reference.
module tb_decode_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  imm_type;
    logic        pc2r;
    logic [3:0]  alu;
    logic [2:0]  btype;
    logic [1:0]  pcsrc;
    logic        mw;
    logic        mr;
    logic        rdsrc;
    logic        m2r;
    logic        alusrc;
    logic        rw;
    logic [2:0]  dsize;
    logic        is_mul;
    logic [2:0]  mul_op;
    logic        illegal;
  } bun_t;

  logic        clk, rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        rdy0, vld0, rdy1, vld1;
  wire bun_t   o0, o1;
  int          n_chk = 0;
  int          n_fail = 0;
  bun_t        q0[$], k0[$], q1[$], k1[$];

  decode_stage #(.XLEN(32), .ENABLE_M(0), .DEPTH(2)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld0), .out_ready(out_ready),
    .out_pc(o0.pc), .rs1(o0.rs1), .rs2(o0.rs2), .rd(o0.rd), .imm(o0.imm),
    .ImmType(o0.imm_type), .PCtoRegSrc(o0.pc2r), .ALUType(o0.alu), .BType(o0.btype),
    .PCSrc(o0.pcsrc), .MemWrite(o0.mw), .MemRead(o0.mr), .RDSrc(o0.rdsrc),
    .MemtoRegSrc(o0.m2r), .ALUSrc(o0.alusrc), .RegWrite(o0.rw), .DataSize(o0.dsize),
    .is_mul(o0.is_mul), .mul_op(o0.mul_op), .illegal(o0.illegal));

  decode_stage #(.XLEN(32), .ENABLE_M(1), .DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(vld1), .out_ready(out_ready),
    .out_pc(o1.pc), .rs1(o1.rs1), .rs2(o1.rs2), .rd(o1.rd), .imm(o1.imm),
    .ImmType(o1.imm_type), .PCtoRegSrc(o1.pc2r), .ALUType(o1.alu), .BType(o1.btype),
    .PCSrc(o1.pcsrc), .MemWrite(o1.mw), .MemRead(o1.mr), .RDSrc(o1.rdsrc),
    .MemtoRegSrc(o1.m2r), .ALUSrc(o1.alusrc), .RegWrite(o1.rw), .DataSize(o1.dsize),
    .is_mul(o1.is_mul), .mul_op(o1.mul_op), .illegal(o1.illegal));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: e = expected bundle, m = which fields are meaningful.
  function automatic void model(input logic [31:0] ins, input logic [31:0] pc, input bit em,
                                output bun_t e, output bun_t m);
    logic [4:0]  op = ins[6:2];
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    bit          ill = 0;
    e = '0;
    m = '1;
    e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.btype = 3'b010;
    if (ins[1:0] != 2'b11) ill = 1;
    else if (op == 5'h0C) begin
      e.alusrc = 1; e.rw = 1;
      if (f7 == 0) e.alu = {1'b0, f3};
      else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) e.alu = {1'b1, f3};
      else if (f7 == 7'h01 && em) begin e.is_mul = 1; e.mul_op = f3; end
      else ill = 1;
    end else if (op == 5'h04) begin
      e.imm_type = 1; e.rw = 1;
      e.alu = (f3 == 5 && ins[30]) ? {1'b1, f3} : {1'b0, f3};
      if (f3 == 1 && f7 != 0) ill = 1;
      if (f3 == 5 && f7 != 0 && f7 != 7'h20) ill = 1;
    end else if (op == 5'h00) begin
      e.imm_type = 1; e.mr = 1; e.m2r = 1; e.rw = 1; e.dsize = f3;
      if (f3 == 3 || f3 == 6 || f3 == 7) ill = 1;
    end else if (op == 5'h08) begin
      e.imm_type = 2; e.mw = 1; e.dsize = f3;
      if (f3 > 2) ill = 1;
    end else if (op == 5'h18) begin
      e.imm_type = 3; e.btype = f3; e.alu = {1'b0, f3}; e.pcsrc = 3;
      if (f3 == 2 || f3 == 3) ill = 1;
    end else if (op == 5'h19) begin
      e.imm_type = 1; e.pcsrc = 2; e.rdsrc = 1; e.rw = 1; e.btype = 0;
      if (f3 != 0) ill = 1;
    end else if (op == 5'h1B) begin
      e.imm_type = 5; e.pcsrc = 1; e.rdsrc = 1; e.rw = 1; e.alu = 4'hf;
    end else if (op == 5'h05) begin
      e.imm_type = 4; e.pc2r = 1; e.rdsrc = 1; e.rw = 1; e.alu = 4'hf;
    end else if (op == 5'h0D) begin
      e.imm_type = 4; e.rw = 1; e.alu = 4'hf;
    end else ill = 1;
    case (e.imm_type)
      1: e.imm = (sx << 12) | ins[31:20];
      2: e.imm = (sx << 12) | (ins[31:25] << 5) | ins[11:7];
      3: e.imm = (sx << 12) | (ins[7] << 11) | (ins[30:25] << 5) | (ins[11:8] << 1);
      4: e.imm = ins & 32'hFFFF_F000;
      5: e.imm = (sx << 20) | (ins[19:12] << 12) | (ins[20] << 11) | (ins[30:21] << 1);
      default: e.imm = 0;
    endcase
    if (ill) begin
      e.illegal = 1; e.rw = 0; e.mw = 0; e.mr = 0; e.pcsrc = 0;
      m = '0;
      m.pc = '1; m.rs1 = '1; m.rs2 = '1; m.rd = '1;
      m.rw = '1; m.mw = '1; m.mr = '1; m.pcsrc = '1; m.illegal = '1;
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom();
    logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6F, 7'h33};
    logic [6:0]  f7s [4]  = '{7'h00, 7'h20, 7'h01, 7'h00};
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 3) != 0) r[31:25] = f7s[$urandom_range(0, 3)];
    return r;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (vld0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_hs: got vld=%b rdy=%b want vld=0 rdy=1", vld0, rdy0);
    end
    n_chk++;
    if (o0 !== '0 || o1 !== '0) begin
      n_fail++; $display("FAIL reset_outs: got %h / %h want all zero", o0, o1);
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (vld0 !== 1'b0 || vld1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got vld0=%b vld1=%b want 0", vld0, vld1);
    end
  endtask

  task automatic test_addi();
    in_valid = 1; in_instr = 32'hFFF0_0093; in_pc = 32'h100;
    @(negedge clk);
    in_valid = 0;
    n_chk++;
    if (vld0 !== 1'b1 || o0.pc !== 32'h100) begin
      n_fail++; $display("FAIL addi_latency: got vld=%b pc=%h want 1 / 00000100", vld0, o0.pc);
    end
    n_chk++;
    if (o0.imm !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL addi_imm: got %h want ffffffff", o0.imm);
    end
    n_chk++;
    if ({o0.imm_type, o0.alu, o0.rd, o0.rw, o0.illegal} !== {3'd1, 4'b0000, 5'd1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL addi_ctrl: got immtype=%0d alu=%b rd=%0d rw=%b ill=%b want 1 0000 1 1 0",
                         o0.imm_type, o0.alu, o0.rd, o0.rw, o0.illegal);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_srai_sub();
    in_valid = 1; in_instr = 32'h4030_D113; in_pc = 32'h104;
    @(negedge clk);
    in_instr = 32'h4020_8033; in_pc = 32'h108;
    @(negedge clk);
    in_valid = 0;
    n_chk++;
    if (o0.alu !== 4'b1101 || o0.imm[4:0] !== 5'd3 || o0.illegal !== 1'b0) begin
      n_fail++; $display("FAIL srai: got alu=%b shamt=%0d ill=%b want 1101 3 0", o0.alu, o0.imm[4:0], o0.illegal);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    n_chk++;
    if ({o0.pc, o0.alu, o0.alusrc, o0.rs1, o0.rs2} !== {32'h108, 4'b1000, 1'b1, 5'd1, 5'd2}) begin
      n_fail++; $display("FAIL sub: got pc=%h alu=%b alusrc=%b rs1=%0d rs2=%0d want 108 1000 1 1 2",
                         o0.pc, o0.alu, o0.alusrc, o0.rs1, o0.rs2);
    end
    out_ready = 1;
    repeat (2) @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_mul();
    in_valid = 1; in_instr = 32'h0220_8033; in_pc = 32'h10C;
    @(negedge clk);
    in_valid = 0;
    n_chk++;
    if (o0.illegal !== 1'b1 || o0.rw !== 1'b0) begin
      n_fail++; $display("FAIL mul_disabled: got ill=%b rw=%b want 1 0", o0.illegal, o0.rw);
    end
    n_chk++;
    if (o1.is_mul !== 1'b1 || o1.mul_op !== 3'b000 || o1.illegal !== 1'b0 || o1.rw !== 1'b1) begin
      n_fail++; $display("FAIL mul_enabled: got is_mul=%b op=%b ill=%b rw=%b want 1 000 0 1",
                         o1.is_mul, o1.mul_op, o1.illegal, o1.rw);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    in_valid = 1; in_instr = 32'h0; in_pc = 32'h110;
    @(negedge clk);
    in_valid = 0;
    n_chk++;
    if (o0.illegal !== 1'b1 || o1.illegal !== 1'b1 || o0.rw !== 1'b0) begin
      n_fail++; $display("FAIL zero_instr: got ill0=%b ill1=%b rw=%b want 1 1 0", o0.illegal, o1.illegal, o0.rw);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    out_ready = 0; in_valid = 1; in_instr = 32'h0010_0093;
    in_pc = 32'h200;
    @(negedge clk);
    in_pc = 32'h204;
    @(negedge clk);
    in_pc = 32'h208;
    n_chk++;
    if (rdy0 !== 1'b0 || vld0 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_full: got rdy=%b vld=%b want 0 1", rdy0, vld0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    n_chk++;
    if (rdy0 !== 1'b1 || o0.pc !== 32'h204) begin
      n_fail++; $display("FAIL b2b_pop1: got rdy=%b pc=%h want 1 00000204", rdy0, o0.pc);
    end
    @(negedge clk);
    in_valid = 0;
    n_chk++;
    if (rdy0 !== 1'b0 || o0.pc !== 32'h204) begin
      n_fail++; $display("FAIL b2b_third: got rdy=%b pc=%h want 0 00000204", rdy0, o0.pc);
    end
    out_ready = 1;
    @(negedge clk);
    n_chk++;
    if (o0.pc !== 32'h208) begin
      n_fail++; $display("FAIL b2b_order: got pc=%h want 00000208", o0.pc);
    end
    @(negedge clk);
    out_ready = 0;
    n_chk++;
    if (vld0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got vld=%b want 0", vld0);
    end
  endtask

  task automatic test_flush();
    in_valid = 1; in_instr = 32'h0010_0093; in_pc = 32'h300;
    @(negedge clk);
    in_pc = 32'h304;
    @(negedge clk);
    flush = 1; in_pc = 32'h308; out_ready = 1;
    @(negedge clk);
    flush = 0; in_valid = 0; out_ready = 0;
    n_chk++;
    if (vld0 !== 1'b0 || rdy0 !== 1'b1 || o0 !== '0) begin
      n_fail++; $display("FAIL flush: got vld=%b rdy=%b outs=%h want 0 1 zero", vld0, rdy0, o0);
    end
    @(negedge clk);
    n_chk++;
    if (vld0 !== 1'b0 || vld1 !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop: got vld0=%b vld1=%b want 0", vld0, vld1);
    end
  endtask

  task automatic test_async_reset();
    bun_t e, m;
    in_valid = 1; in_instr = 32'h0010_0093; in_pc = 32'h400;
    @(negedge clk);
    in_pc = 32'h404;
    @(negedge clk);
    in_valid = 0;
    #2 rst = 0;
    #1;
    n_chk++;
    if (vld0 !== 1'b0 || rdy0 !== 1'b1 || o0 !== '0) begin
      n_fail++; $display("FAIL async_reset: got vld=%b rdy=%b outs=%h want 0 1 zero", vld0, rdy0, o0);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    in_valid = 1; in_instr = 32'h8000_0AB7; in_pc = 32'h500;
    model(in_instr, in_pc, 0, e, m);
    @(negedge clk);
    in_valid = 0;
    n_chk++;
    if (vld0 !== 1'b1 || (o0 & m) !== (e & m)) begin
      n_fail++; $display("FAIL post_reset_push: got vld=%b %h want 1 %h", vld0, o0, e);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_random();
    bun_t e, m;
    bit   push, pop;
    q0.delete(); k0.delete(); q1.delete(); k1.delete();
    for (int c = 0; c < 800; c++) begin
      n_chk++;
      if (vld0 !== (q0.size() > 0) || rdy0 !== (q0.size() < 2) ||
          vld1 !== (q1.size() > 0) || rdy1 !== (q1.size() < 2)) begin
        n_fail++; $display("FAIL rand_hs[%0d]: got vld=%b%b rdy=%b%b want occupancy %0d",
                           c, vld0, vld1, rdy0, rdy1, q0.size());
      end
      if (q0.size() > 0) begin
        n_chk++;
        if ((o0 & k0[0]) !== (q0[0] & k0[0])) begin
          n_fail++; $display("FAIL rand_m0[%0d]: got %h want %h", c, o0, q0[0]);
        end
      end
      if (q1.size() > 0) begin
        n_chk++;
        if ((o1 & k1[0]) !== (q1[0] & k1[0])) begin
          n_fail++; $display("FAIL rand_m1[%0d]: got %h want %h", c, o1, q1[0]);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom() & 32'hFFFF_FFFC;
      if (flush) begin
        q0.delete(); k0.delete(); q1.delete(); k1.delete();
      end else begin
        push = in_valid && (q0.size() < 2);
        pop  = out_ready && (q0.size() > 0);
        if (pop) begin
          void'(q0.pop_front()); void'(k0.pop_front());
          void'(q1.pop_front()); void'(k1.pop_front());
        end
        if (push) begin
          model(in_instr, in_pc, 0, e, m); q0.push_back(e); k0.push_back(m);
          model(in_instr, in_pc, 1, e, m); q1.push_back(e); k1.push_back(m);
        end
      end
      @(negedge clk);
    end
    in_valid = 0; out_ready = 0; flush = 0;
  endtask

  initial begin
    rst = 0; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
    test_reset();
    test_addi();
    test_srai_sub();
    test_mul();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
